// File: rtl/rr_mux4_arbiter_if.sv
// rr_mux4_arbiter_if: bundles the requester-side request/data bus and the
// arbiter-side grant/select/shared-data outputs of the 4-way round-robin mux.
// The "slave" modport is the arbiter's view; "master" is the requester side.
interface rr_mux4_arbiter_if #(
    parameter int DW = 8
);
    logic [3:0]      req;      // per-requester request, bit i = requester i
    logic [4*DW-1:0] I;        // packed requester data, requester i at [i*DW +: DW]
    logic [3:0]      gnt;      // registered one-hot grant, or all zero
    logic [1:0]      s;        // registered mux select (current/last owner)
    logic [DW-1:0]   f;        // shared output data
    logic            f_valid;  // f carries data of an active grant

    modport master (
        output req,
        output I,
        input  gnt,
        input  s,
        input  f,
        input  f_valid
    );

    modport slave (
        input  req,
        input  I,
        output gnt,
        output s,
        output f,
        output f_valid
    );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter: 4-requester round-robin arbiter driving a shared data mux.
// Grants are registered (one-cycle latency); the owner keeps the grant while
// it holds its request, and hand-over to another requester has no idle bubble.
// Optional feature macro: ARB_BURST_LIMIT_EN -- when defined, an owner is
// forced off after MAX_BURST consecutive grant cycles if someone else waits.
module rr_mux4_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    rr_mux4_arbiter_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [3:0]      r_gnt;
    logic [1:0]      r_s;
    logic [1:0]      r_ptr;

    logic            w_new_grant;
    logic [1:0]      w_winner;
    logic            w_force_switch;
    logic [3:0]      w_req_others;
    logic [2:0]      w_from_ptr;
    logic [2:0]      w_from_next;
    logic [DW-1:0]   w_chan [4];

    // Reject burst lengths the 8-bit counter cannot represent.
    if ((MAX_BURST < 1) || (MAX_BURST > 255)) begin : g_bad_max_burst
        $error("rr_mux4_arbiter: MAX_BURST must be in 1..255");
    end

    // Search order start, start+1, start+2, start+3 (mod 4); first set bit wins.
    // Returns {found, index}.
    function automatic logic [2:0] rr_search(input logic [3:0] req_vec,
                                             input logic [1:0] start);
        logic       found;
        logic [1:0] idx;
        logic [1:0] win;
        found = 1'b0;
        win   = start;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && req_vec[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    // Requests of everyone except the current owner; used for hand-over.
    assign w_req_others = bus.req & ~(4'b0001 << r_s);
    assign w_from_ptr   = rr_search(bus.req, r_ptr);
    assign w_from_next  = rr_search(w_req_others, r_s + 2'd1);

`ifdef ARB_BURST_LIMIT_EN
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    logic [7:0] r_cnt;

    // Owner has used its full burst and somebody else is waiting.
    assign w_force_switch = (r_state == GRANT) && (r_cnt == BURST_LAST) && (|w_req_others);

    // Count grant cycles of the current owner; restart on every new grant,
    // saturate at the last burst slot while nobody else competes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (w_new_grant) begin
            r_cnt <= 8'd0;
        end else if ((r_state == GRANT) && (w_state_next == GRANT) && (r_cnt != BURST_LAST)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    assign w_force_switch = 1'b0;
`endif

    // Next-state and winner selection.
    always_comb begin
        w_state_next = r_state;
        w_new_grant  = 1'b0;
        w_winner     = r_s;
        case (r_state)
            IDLE: begin
                if (w_from_ptr[2]) begin
                    w_state_next = GRANT;
                    w_new_grant  = 1'b1;
                    w_winner     = w_from_ptr[1:0];
                end
            end
            GRANT: begin
                // Hand over when the owner lets go or its burst is used up;
                // a forced switch implies another requester exists.
                if (!bus.req[r_s] || w_force_switch) begin
                    if (w_from_next[2]) begin
                        w_new_grant = 1'b1;
                        w_winner    = w_from_next[1:0];
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, grant, select and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_s     <= 2'd0;
            r_ptr   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            if (w_new_grant) begin
                r_gnt <= 4'b0001 << w_winner;
                r_s   <= w_winner;
                r_ptr <= w_winner + 2'd1;
            end else if (w_state_next == IDLE) begin
                r_gnt <= 4'b0000;
            end
        end
    end

    // Unpack the requester data bus into per-channel words.
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
        assign w_chan[gi] = bus.I[gi*DW +: DW];
    end

    assign bus.gnt     = r_gnt;
    assign bus.s       = r_s;
    assign bus.f       = w_chan[r_s];
    assign bus.f_valid = |(r_gnt & bus.req);

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// tb_rr_mux4_arbiter: directed self-checking bench for rr_mux4_arbiter.
// Expectations follow the ARB_BURST_LIMIT_EN setting of the build.
module tb_rr_mux4_arbiter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    rr_mux4_arbiter_if #(.DW(8)) bus ();

    rr_mux4_arbiter #(.DW(8), .MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse, released away from the clock edge, with req cleared.
    task automatic do_reset();
        bus.req = 4'b0000;
        rst = 1'b1;
        tick();
        #2;
        rst = 1'b0;
    endtask

    // Reference winner: rotate req so ptr sits at bit 0, take lowest set bit.
    function automatic logic [3:0] exp_gnt(input logic [3:0] r, input int p);
        logic [7:0] dbl;
        logic [3:0] rot;
        int         off;
        if (r == 4'b0000) return 4'b0000;
        dbl = {r, r};
        rot = 4'(dbl >> p);
        off = 0;
        while (rot[off] == 1'b0) off++;
        return 4'b0001 << ((p + off) % 4);
    endfunction

    task automatic test_reset();
        bus.I   = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req = 4'b0001;
        rst     = 1'b1;
        #1;
        n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want %b", bus.gnt, 4'b0000); end
        tick();
        n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt_clk: got %b want %b", bus.gnt, 4'b0000); end
        n_tests++; if (bus.s !== 2'd0) begin n_fail++; $display("FAIL reset_s: got %0d want 0", bus.s); end
        n_tests++; if (bus.f_valid !== 1'b0) begin n_fail++; $display("FAIL reset_f_valid: got %b want 0", bus.f_valid); end
        $display("[TB] test_reset gnt=%b s=%0d f_valid=%b", bus.gnt, bus.s, bus.f_valid);
    endtask

    task automatic test_first_grant();
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL first_latency: got %b want %b", bus.gnt, 4'b0000); end
        tick();
        n_tests++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL first_gnt: got %b want %b", bus.gnt, 4'b0001); end
        n_tests++; if (bus.s !== 2'd0) begin n_fail++; $display("FAIL first_s: got %0d want 0", bus.s); end
        n_tests++; if (bus.f !== 8'h11) begin n_fail++; $display("FAIL first_f: got %h want 11", bus.f); end
        n_tests++; if (bus.f_valid !== 1'b1) begin n_fail++; $display("FAIL first_f_valid: got %b want 1", bus.f_valid); end
        $display("[TB] test_first_grant gnt=%b f=%h", bus.gnt, bus.f);
    endtask

    task automatic test_rotation();
        logic [3:0] drops [4];
        logic [3:0] order [5];
        logic [7:0] data  [4];
        drops = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        data  = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        bus.req = 4'b1111;
        tick();
        n_tests++; if (bus.gnt !== order[0]) begin n_fail++; $display("FAIL rot_gnt0: got %b want %b", bus.gnt, order[0]); end
        for (int i = 0; i < 4; i++) begin
            bus.req = drops[i];
            #1;
            n_tests++; if (bus.f_valid !== 1'b0) begin n_fail++; $display("FAIL rot_drop_valid%0d: got %b want 0", i, bus.f_valid); end
            tick();
            n_tests++; if (bus.gnt !== order[i+1]) begin n_fail++; $display("FAIL rot_gnt%0d: got %b want %b", i + 1, bus.gnt, order[i+1]); end
            n_tests++; if (bus.f !== data[(i+1)%4]) begin n_fail++; $display("FAIL rot_f%0d: got %h want %h", i + 1, bus.f, data[(i+1)%4]); end
            n_tests++; if (bus.f_valid !== 1'b1) begin n_fail++; $display("FAIL rot_valid%0d: got %b want 1", i + 1, bus.f_valid); end
            $display("[TB] test_rotation step %0d gnt=%b", i + 1, bus.gnt);
        end
    endtask

    task automatic test_idle_return();
        do_reset();
        bus.req = 4'b0100;
        tick();
        n_tests++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL idle_own2: got %b want %b", bus.gnt, 4'b0100); end
        bus.req = 4'b0000;
        tick();
        n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_gnt: got %b want %b", bus.gnt, 4'b0000); end
        n_tests++; if (bus.s !== 2'd2) begin n_fail++; $display("FAIL idle_s: got %0d want 2", bus.s); end
        n_tests++; if (bus.f !== 8'h33) begin n_fail++; $display("FAIL idle_f: got %h want 33", bus.f); end
        n_tests++; if (bus.f_valid !== 1'b0) begin n_fail++; $display("FAIL idle_f_valid: got %b want 0", bus.f_valid); end
        bus.req = 4'b1001;
        tick();
        n_tests++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL idle_ptr3: got %b want %b", bus.gnt, 4'b1000); end
        n_tests++; if (bus.s !== 2'd3) begin n_fail++; $display("FAIL idle_ptr3_s: got %0d want 3", bus.s); end
        $display("[TB] test_idle_return gnt=%b s=%0d", bus.gnt, bus.s);
    endtask

    task automatic test_burst();
        logic [3:0] want;
        do_reset();
        bus.req = 4'b0011;
        for (int c = 0; c < 12; c++) begin
            tick();
`ifdef ARB_BURST_LIMIT_EN
            want = (((c / 4) % 2) == 1) ? 4'b0010 : 4'b0001;
`else
            want = 4'b0001;
`endif
            n_tests++; if (bus.gnt !== want) begin n_fail++; $display("FAIL burst_c%0d: got %b want %b", c, bus.gnt, want); end
            $display("[TB] test_burst cycle %0d gnt=%b", c, bus.gnt);
        end
        // A lone owner keeps the grant past the burst length.
        do_reset();
        bus.req = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_tests++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL burst_sat_c%0d: got %b want %b", c, bus.gnt, 4'b0001); end
        end
        $display("[TB] test_burst lone owner gnt=%b", bus.gnt);
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 4'b0100;
        tick();
        n_tests++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL arst_pre: got %b want %b", bus.gnt, 4'b0100); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL arst_gnt: got %b want %b", bus.gnt, 4'b0000); end
        n_tests++; if (bus.f_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", bus.f_valid); end
        bus.req = 4'b0110;
        tick();
        #2;
        rst = 1'b0;
        tick();
        n_tests++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL arst_restart: got %b want %b", bus.gnt, 4'b0010); end
        $display("[TB] test_async_reset restart gnt=%b", bus.gnt);
    endtask

    task automatic test_exhaustive();
        logic [3:0] r;
        logic [3:0] want;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int v = 0; v < 16; v++) begin
                // Prime ptr = p: grant requester p-1 alone, then go idle.
                bus.req = 4'b0001 << ((p + 3) % 4);
                tick();
                bus.req = 4'b0000;
                tick();
                r = 4'(v);
                bus.req = r;
                tick();
                want = exp_gnt(r, p);
                n_tests++; if (bus.gnt !== want) begin n_fail++; $display("FAIL exh_p%0d_r%b: got %b want %b", p, r, bus.gnt, want); end
                bus.req = 4'b0000;
                tick();
            end
            $display("[TB] test_exhaustive ptr=%0d done", p);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        bus.req = 4'b0000;
        bus.I   = '0;
        test_reset();
        test_first_grant();
        test_rotation();
        test_idle_return();
        test_burst();
        test_async_reset();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
